// File: rtl/alu_seq.sv
// alu_seq: multi-nibble operation sequencer in front of a combinational 4-bit ALU.
//
// Accepts one W-bit operation (W = 4*NIBBLES) over a valid/ready handshake and
// walks the ALU through the operands one nibble per cycle, LSB nibble first.
// Carry and borrow are chained between nibbles. Shift bits that cross a nibble
// boundary are patched in. The assembled result is returned with full-width
// flags.
//
// Build option: define ALU_SEQ_CARRY_IN_EN to add the in_cin port. in_cin seeds
// the first-nibble carry (ADD) or borrow (SUB). Without the macro the seed is 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operation request handshake (in_ready high only in IDLE)
//   in_op               000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                       101 NOT(a), 110 SHL(a), 111 SHR(a)
//   in_a, in_b          operands (in_b ignored by NOT/SHL/SHR)
//   in_cin              carry/borrow seed (ALU_SEQ_CARRY_IN_EN only)
//   out_valid/out_ready result handshake
//   out_c               result
//   out_flags           [0] carry/shift-out, [1] borrow, [2] zero, [3] unsigned a<b
//   alu_a, alu_b        ALU operand nibbles
//   alu_mode            ALU mode
//   alu_carry_f         ALU carry-in
//   alu_borrow_f        ALU borrow-in
//   alu_c, alu_flags    ALU result nibble and flags ([0] carry, [1] borrow, [3] a<b)
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// RUN   | driving nibble idx_q into the ALU and capturing its result
// DONE  | first cycle publishes the result registers, then holds until out_ready

module alu_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
`ifdef ALU_SEQ_CARRY_IN_EN
  input  logic         in_cin,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic [3:0]   out_flags,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_mode,
  output logic         alu_carry_f,
  output logic         alu_borrow_f,
  input  logic [3:0]   alu_c,
  input  logic [3:0]   alu_flags
);

  localparam int IDX_W = $clog2(NIBBLES);
  localparam int BASE_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [W-1:0]       a_q, b_q, res_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q, borrow_q, lt_q;

  logic [BASE_W-1:0]  base;
  logic [3:0]         a_nib, b_nib;
  logic [W-1:0]       shl_full, shr_full;
  logic [3:0]         patch;
  logic [3:0]         res_nib;
  logic [3:0]         mode_run;
  logic               seed;
  logic               flag_c, flag_b;
  logic               accept;

  // The ALU's own zero flag only covers one nibble; the full-width zero flag
  // comes from the assembled result instead.
  logic               unused_alu_zero;
  assign unused_alu_zero = alu_flags[2];

`ifdef ALU_SEQ_CARRY_IN_EN
  assign seed = in_cin;
`else
  assign seed = 1'b0;
`endif

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  assign base  = {idx_q, 2'b00};
  assign a_nib = a_q[base +: 4];
  assign b_nib = b_q[base +: 4];

  // Whole-operand shifts give the bit that must cross into nibble idx_q:
  // bit 0 of the left-shifted nibble is a[4i-1], and bit 3 of the
  // right-shifted nibble is a[4i+4]. The zero fill at each end is the
  // required boundary value.
  assign shl_full = a_q << 1;
  assign shr_full = a_q >> 1;

  always_comb begin
    patch = 4'h0;
    if (op_q == OP_SHL) begin
      patch = shl_full[base +: 4] & 4'b0001;
    end else if (op_q == OP_SHR) begin
      patch = shr_full[base +: 4] & 4'b1000;
    end
  end

  assign res_nib = alu_c | patch;

  always_comb begin
    mode_run = 4'b0000;
    case (op_q)
      OP_ADD:  mode_run = 4'b0001;
      OP_SUB:  mode_run = 4'b0011;
      OP_AND:  mode_run = 4'b0110;
      OP_OR:   mode_run = 4'b0111;
      OP_XOR:  mode_run = 4'b1001;
      OP_NOT:  mode_run = 4'b1000;
      OP_SHL:  mode_run = 4'b0100;
      OP_SHR:  mode_run = 4'b0101;
      default: mode_run = 4'b0000;
    endcase
  end

  always_comb begin
    flag_c = 1'b0;
    case (op_q)
      OP_ADD:  flag_c = carry_q;
      OP_SHL:  flag_c = a_q[W-1];
      OP_SHR:  flag_c = a_q[0];
      default: flag_c = 1'b0;
    endcase
  end

  assign flag_b = (op_q == OP_SUB) & borrow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The ALU only sees operands while RUN is active. Outside RUN every
  // alu_* output is 0.
  always_comb begin
    state_d      = state_q;
    alu_a        = 4'h0;
    alu_b        = 4'h0;
    alu_mode     = 4'h0;
    alu_carry_f  = 1'b0;
    alu_borrow_f = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        alu_a        = a_nib;
        alu_b        = b_nib;
        alu_mode     = mode_run;
        alu_carry_f  = (op_q == OP_ADD) & carry_q;
        alu_borrow_f = (op_q == OP_SUB) & borrow_q;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 3'b000;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      lt_q      <= 1'b0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_flags <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q     <= in_op;
            a_q      <= in_a;
            b_q      <= in_b;
            res_q    <= '0;
            idx_q    <= '0;
            carry_q  <= seed;
            borrow_q <= seed;
            lt_q     <= 1'b0;
          end
        end
        RUN: begin
          res_q[base +: 4] <= res_nib;
          if (op_q == OP_ADD) carry_q  <= alu_flags[0];
          if (op_q == OP_SUB) borrow_q <= alu_flags[1];
          // LSB-first compare: a strictly-less nibble decides unless a
          // higher nibble overrides it. Equal nibbles keep the earlier verdict.
          lt_q  <= alu_flags[3] | ((a_nib == b_nib) & lt_q);
          idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        DONE: begin
          // The first DONE cycle loads the output registers. The zero
          // detect then sees the complete patched result.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_c     <= res_q;
            out_flags <= {lt_q, (res_q == '0), flag_b, flag_c};
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
`ifdef ALU_SEQ_CARRY_IN_EN
  logic         in_cin;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic [3:0]   out_flags;
  logic [3:0]   alu_a, alu_b, alu_mode;
  logic         alu_carry_f, alu_borrow_f;
  logic [3:0]   alu_c, alu_flags;
  logic [4:0]   alu_t;

  int n_checks;
  int n_fail;

  alu_seq #(.NIBBLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
`ifdef ALU_SEQ_CARRY_IN_EN
    .in_cin       (in_cin),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_c        (out_c),
    .out_flags    (out_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_mode     (alu_mode),
    .alu_carry_f  (alu_carry_f),
    .alu_borrow_f (alu_borrow_f),
    .alu_c        (alu_c),
    .alu_flags    (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external combinational 4-bit ALU.
  always_comb begin
    alu_t     = 5'h00;
    alu_c     = 4'h0;
    alu_flags = 4'h0;
    case (alu_mode)
      4'b0001: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_carry_f};
        alu_c = alu_t[3:0];
        alu_flags[0] = alu_t[4];
      end
      4'b0011: begin
        alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0000, alu_borrow_f};
        alu_c = alu_t[3:0];
        alu_flags[1] = alu_t[4];
      end
      4'b0110: alu_c = alu_a & alu_b;
      4'b0111: alu_c = alu_a | alu_b;
      4'b1001: alu_c = alu_a ^ alu_b;
      4'b1000: alu_c = ~alu_a;
      4'b0100: alu_c = {alu_a[2:0], 1'b0};
      4'b0101: alu_c = {1'b0, alu_a[3:1]};
      default: alu_c = 4'h0;
    endcase
    alu_flags[2] = (alu_c == 4'h0);
    alu_flags[3] = (alu_a < alu_b);
  end

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [3:0]   f;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one operation and returns once out_valid is seen (or the budget
  // runs out). lat counts the edges from the accept edge to out_valid.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handshake_in_ready", {31'b0, in_ready}, 32'd1);
    check("handshake_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_c;
    logic [3:0]   held_f;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
`ifdef ALU_SEQ_CARRY_IN_EN
    in_cin    = 1'b0;
`endif

    //            op       a         b         c         flags
    vecs[0]  = '{3'b000, 16'h0FFF, 16'h0001, 16'h1000, 4'b0000};
    vecs[1]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101};
    vecs[2]  = '{3'b001, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010};
    vecs[3]  = '{3'b001, 16'h1000, 16'h0001, 16'h0FFF, 4'b0000};
    vecs[4]  = '{3'b110, 16'h8421, 16'h0000, 16'h0842, 4'b0001};
    vecs[5]  = '{3'b111, 16'h8421, 16'h0000, 16'h4210, 4'b0001};
    vecs[6]  = '{3'b100, 16'hA5A5, 16'hA5A5, 16'h0000, 4'b0100};
    vecs[7]  = '{3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
    vecs[8]  = '{3'b011, 16'h1200, 16'h0034, 16'h1234, 4'b0000};
    vecs[9]  = '{3'b101, 16'h00FF, 16'h0100, 16'hFF00, 4'b1000};
    vecs[10] = '{3'b110, 16'h0001, 16'h0000, 16'h0002, 4'b0000};
    vecs[11] = '{3'b111, 16'h0001, 16'h0000, 16'h0000, 4'b0101};
    vecs[12] = '{3'b000, 16'h1234, 16'h1111, 16'h2345, 4'b0000};
    vecs[13] = '{3'b001, 16'h5555, 16'h5555, 16'h0000, 4'b0100};
    vecs[14] = '{3'b110, 16'h8000, 16'h0000, 16'h0000, 4'b0101};

    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_c", {16'b0, out_c}, 32'h0);
    check("rst_out_flags", {28'b0, out_flags}, 32'h0);
    check("rst_alu_drive", {20'b0, alu_a, alu_b, alu_mode}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd5);
      check($sformatf("v%0d_out_c", i), {16'b0, out_c}, {16'b0, vecs[i].c});
      check($sformatf("v%0d_flags", i), {28'b0, out_flags}, {28'b0, vecs[i].f});
      release_result();
    end

    // Back-pressure: DONE holds with out_ready low and ignores new requests.
    run_op(3'b000, 16'h0FFF, 16'h0001, lat);
    check("hold_latency", lat, 32'd5);
    held_c = out_c;
    held_f = out_flags;
    check("hold_first_c", {16'b0, held_c}, 32'h1000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 3'b100;
      in_a     = 16'hFFFF;
      in_b     = 16'h1234;
      @(posedge clk);
      #1;
      check("hold_out_c", {16'b0, out_c}, 32'h1000);
      check("hold_out_flags", {28'b0, out_flags}, 32'h0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_ghost_op", {31'b0, out_valid}, 32'd0);
    check("idle_alu_mode", {28'b0, alu_mode}, 32'h0);

    // Reset in the middle of RUN, while nibble 2 is on the ALU.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'b000;
    in_a     = 16'h1234;
    in_b     = 16'h1111;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_run_alu_a", {28'b0, alu_a}, 32'h2);
    check("mid_run_alu_b", {28'b0, alu_b}, 32'h1);
    check("mid_run_alu_mode", {28'b0, alu_mode}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_out_c", {16'b0, out_c}, 32'h0);
    check("async_rst_out_flags", {28'b0, out_flags}, 32'h0);
    check("async_rst_alu", {20'b0, alu_a, alu_b, alu_mode}, 32'h0);
    check("async_rst_cb", {30'b0, alu_carry_f, alu_borrow_f}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    run_op(3'b000, 16'h0003, 16'h0004, lat);
    check("post_rst_latency", lat, 32'd5);
    check("post_rst_out_c", {16'b0, out_c}, 32'h0007);
    check("post_rst_flags", {28'b0, out_flags}, 32'h8);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
